// File: rtl/filter_window_ctrl_if.sv
// Pixel-word input stream and window output stream of filter_window_ctrl.
// master = the window controller, slave = the surrounding upstream/downstream logic.
interface filter_window_ctrl_if;
   logic [127:0] in_vec;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] dp_vec;
   logic [1:0]   dp_offset;
   logic         win_valid;
   logic         win_ready;
   logic         win_last_col;
   logic         win_last_line;

   modport master (
      input  in_vec, in_valid, win_ready,
      output in_ready, dp_vec, dp_offset, win_valid, win_last_col, win_last_line
   );

   modport slave (
      output in_vec, in_valid, win_ready,
      input  in_ready, dp_vec, dp_offset, win_valid, win_last_col, win_last_line
   );
endinterface

// File: rtl/filter_window_ctrl.sv
// Sequences 3-pixel filter_datapath windows over a raster frame built from 4-pixel input words.
// First window valid 4 cycles after word 0 is accepted, then 1/cycle; win_ready low freezes the window, in_ready drops while the hold word is full.
module filter_window_ctrl #(
   parameter int LINE_PIX = 64,
   parameter int LINES    = 48
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  frame_done,
   filter_window_ctrl_if.master  bus
);
   localparam int TOTAL = LINE_PIX * LINES;
   localparam int CW    = $clog2(TOTAL + 8);
   localparam int KW    = $clog2(LINE_PIX);
   localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [3:0][31:0] slot;
   logic [3:0][31:0] nxt;
   logic             nxt_v;
   logic [CW-1:0]    w;
   logic [CW-1:0]    g;
   logic [KW-1:0]    k;
   logic [LW-1:0]    line;

   logic run, pix_wr, slot3_wr, word_acc, win_vld, win_acc, skip, g_adv, k_wrap, last_win;

   assign run      = (state == RUN);
   // w < g+4 keeps every slot of the current window intact while writes run ahead
   assign pix_wr   = run && nxt_v && (w < g + CW'(4)) && (w < CW'(TOTAL));
   assign slot3_wr = pix_wr && (w[1:0] == 2'd3);
   assign word_acc = bus.in_valid && bus.in_ready;
   assign win_vld  = run && (k <= KW'(LINE_PIX - 3)) && (w >= g + CW'(3));
   assign win_acc  = win_vld && bus.win_ready;
   assign skip     = run && (k > KW'(LINE_PIX - 3));
   assign g_adv    = win_acc || skip;
   assign k_wrap   = (k == KW'(LINE_PIX - 1));
   assign last_win = (line == LW'(LINES - 1)) && (k == KW'(LINE_PIX - 3));

   assign bus.in_ready      = run && (!nxt_v || slot3_wr);
   assign bus.win_valid     = win_vld;
   assign bus.win_last_col  = win_vld && (k == KW'(LINE_PIX - 3));
   assign bus.win_last_line = win_vld && (line == LW'(LINES - 1));
   assign bus.dp_vec        = slot;
   assign bus.dp_offset     = k[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (win_acc && last_win) state_nxt = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w     <= '0;
         g     <= '0;
         k     <= '0;
         line  <= '0;
         nxt   <= '0;
         nxt_v <= 1'b0;
         slot  <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            w     <= '0;
            g     <= '0;
            k     <= '0;
            line  <= '0;
            nxt_v <= 1'b0;
         end
      end else begin
         if (word_acc) begin
            nxt   <= bus.in_vec;
            nxt_v <= 1'b1;
         end else if (slot3_wr) begin
            nxt_v <= 1'b0;
         end
         if (pix_wr) begin
            slot[w[1:0]] <= nxt[w[1:0]];
            w            <= w + CW'(1);
         end
         // the two line-end positions are stepped through without emitting
         if (g_adv) begin
            g <= g + CW'(1);
            if (k_wrap) begin
               k    <= '0;
               line <= line + LW'(1);
            end else begin
               k <= k + KW'(1);
            end
         end
      end
   end
endmodule
